stack_transfer_controller: RTL and testbench

STACK_TRANSFER_CONTROLLER -- requirements
Module: stack_transfer_controller

---
 rtl/stack_transfer_controller_pkg.sv | 28 ++
 rtl/stack_transfer_controller_if.sv | 33 +++
 rtl/stack_transfer_controller_encoder.sv | 22 ++
 rtl/stack_transfer_controller.sv | 103 ++++++++++
 tb/tb_stack_transfer_controller.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/stack_transfer_controller_pkg.sv
// Shared types and constants for the PUSH/POP stack transfer controller.
package stack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] HANDLER_DEFAULT = 3'd0;
    localparam logic [2:0] HANDLER_PUSH    = 3'd1;
    localparam logic [2:0] HANDLER_POP     = 3'd2;

    localparam logic [3:0] LR_INDEX = 4'd14;
    localparam logic [3:0] PC_INDEX = 4'd15;

    localparam int unsigned KERNEL_TOP_DEFAULT    = 4096;
    localparam int unsigned KERNEL_BOTTOM_DEFAULT = 6143;
    localparam int unsigned USER_TOP_DEFAULT      = 6144;
    localparam int unsigned USER_BOTTOM_DEFAULT   = 8191;

    // LR and PC both live in list bit 8.
    function automatic logic [3:0] index_to_bit(input logic [3:0] idx);
        return (idx >= LR_INDEX) ? 4'd8 : idx;
    endfunction

endpackage

// File: rtl/stack_transfer_controller_if.sv
// Request / address-handler / write-back signal bundle of the controller.
interface stack_transfer_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  is_push;
    logic [8:0]            register_list;
    logic                  is_kernel;
    logic [DATA_WIDTH-1:0] current_SP;
    logic [2:0]            handler_control;
    logic [3:0]            reg_index;
    logic                  mem_write_enable;
    logic                  reg_write_enable;
    logic [3:0]            wb_index;
    logic                  busy;
    logic                  stall_pc;
    logic                  done;
    logic                  stack_fault;

    modport master (
        output start, is_push, register_list, is_kernel, current_SP,
        input  handler_control, reg_index, mem_write_enable,
        input  reg_write_enable, wb_index, busy, stall_pc, done,
        input  stack_fault
    );

    modport slave (
        input  start, is_push, register_list, is_kernel, current_SP,
        output handler_control, reg_index, mem_write_enable,
        output reg_write_enable, wb_index, busy, stall_pc, done,
        output stack_fault
    );
endinterface

// File: rtl/stack_transfer_controller_encoder.sv
// Picks the next register of a transfer list: highest bit for push, lowest for pop.
module register_list_encoder
    import stack_pkg::*;
(
    input  logic [8:0] list,
    input  logic       is_push,
    output logic [3:0] index,
    output logic       last
);
    always_comb begin
        index = 4'd0;
        if (is_push) begin
            for (int i = 0; i < 9; i++)
                if (list[i]) index = (i == 8) ? LR_INDEX : 4'(i);
        end else begin
            for (int i = 8; i >= 0; i--)
                if (list[i]) index = (i == 8) ? PC_INDEX : 4'(i);
        end
    end

    assign last = (list & (list - 9'd1)) == 9'd0;
endmodule

// File: rtl/stack_transfer_controller.sv
// Sequences multi-register PUSH/POP one word per cycle with SP bound checking.
module stack_transfer_controller
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] KERNEL_STACK_TOP    = DATA_WIDTH'(KERNEL_TOP_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] KERNEL_STACK_BOTTOM = DATA_WIDTH'(KERNEL_BOTTOM_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] USER_STACK_TOP      = DATA_WIDTH'(USER_TOP_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] USER_STACK_BOTTOM   = DATA_WIDTH'(USER_BOTTOM_DEFAULT)
) (
    input logic                         clock,
    input logic                         reset,
    stack_transfer_controller_if.slave  bus
);
    state_t     state, next_state;
    logic [8:0] list_q, list_d;
    logic       push_q, kernel_q;
    logic       wb_valid;
    logic [3:0] wb_idx;
    logic [3:0] sel;
    logic       last;
    logic       sp_fault;
    logic       pop_issue;
    logic [DATA_WIDTH-1:0] top, bottom;

    register_list_encoder u_enc (
        .list    (list_q),
        .is_push (push_q),
        .index   (sel),
        .last    (last)
    );

    assign top      = kernel_q ? KERNEL_STACK_TOP : USER_STACK_TOP;
    assign bottom   = kernel_q ? KERNEL_STACK_BOTTOM : USER_STACK_BOTTOM;
    assign sp_fault = push_q ? (bus.current_SP <= top) : (bus.current_SP >= bottom);

    always_comb begin
        next_state           = state;
        list_d               = list_q;
        pop_issue            = 1'b0;
        bus.handler_control  = HANDLER_DEFAULT;
        bus.reg_index        = 4'd0;
        bus.mem_write_enable = 1'b0;
        bus.done             = 1'b0;
        bus.stack_fault      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    next_state = (|bus.register_list) ? TRANSFER : DONE;
            end
            TRANSFER: begin
                if (sp_fault) begin
                    bus.stack_fault = 1'b1;
                    next_state      = DONE;
                end else begin
                    bus.handler_control  = push_q ? HANDLER_PUSH : HANDLER_POP;
                    bus.reg_index        = sel;
                    bus.mem_write_enable = push_q;
                    pop_issue            = ~push_q;
                    list_d = list_q & ~(9'd1 << index_to_bit(sel));
                    if (last)
                        next_state = push_q ? DONE : DRAIN;
                end
            end
            DRAIN: next_state = DONE;
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            list_q   <= 9'd0;
            push_q   <= 1'b0;
            kernel_q <= 1'b0;
            wb_valid <= 1'b0;
            wb_idx   <= 4'd0;
        end else begin
            state    <= next_state;
            wb_valid <= pop_issue;
            wb_idx   <= pop_issue ? bus.reg_index : 4'd0;
            if (state == IDLE && bus.start) begin
                list_q   <= bus.register_list;
                push_q   <= bus.is_push;
                kernel_q <= bus.is_kernel;
            end else if (state == DONE) begin
                list_q <= 9'd0;
            end else begin
                list_q <= list_d;
            end
        end
    end

    assign bus.busy             = (state != IDLE);
    // Gate with reset so every output reads zero while reset is held.
    assign bus.stall_pc         = bus.busy | (bus.start & (state == IDLE) & ~reset);
    assign bus.reg_write_enable = wb_valid;
    assign bus.wb_index         = wb_idx;
endmodule

// File: tb/tb_stack_transfer_controller.sv
// Randomized check of the stack transfer controller against a trace model.
module tb_stack_transfer_controller;
    import stack_pkg::*;

    localparam int unsigned K_TOP = 4096;
    localparam int unsigned K_BOT = 6143;
    localparam int unsigned U_TOP = 6144;
    localparam int unsigned U_BOT = 8191;

    typedef struct packed {
        logic [2:0] hc;
        logic [3:0] ri;
        logic       mwe;
        logic       rwe;
        logic [3:0] wbi;
        logic       busy;
        logic       stall;
        logic       done;
        logic       fault;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    obs_t        exp_q[$];
    int unsigned sp_q[$];

    stack_transfer_controller_if #(.DATA_WIDTH(32)) bus ();

    stack_transfer_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic obs_t sample();
        obs_t o;
        o.hc    = bus.handler_control;
        o.ri    = bus.reg_index;
        o.mwe   = bus.mem_write_enable;
        o.rwe   = bus.reg_write_enable;
        o.wbi   = bus.wb_index;
        o.busy  = bus.busy;
        o.stall = bus.stall_pc;
        o.done  = bus.done;
        o.fault = bus.stack_fault;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs after the start cycle, plus the SP the handler holds.
    task automatic build(input logic [8:0] list, input logic push,
                         input logic kernel, input int unsigned sp0);
        int          order[$];
        int unsigned sp;
        int unsigned top, bot;
        bit          faulted;
        obs_t        e;
        exp_q.delete();
        sp_q.delete();
        top = kernel ? K_TOP : U_TOP;
        bot = kernel ? K_BOT : U_BOT;
        if (push) begin
            if (list[8]) order.push_back(14);
            for (int i = 7; i >= 0; i--) if (list[i]) order.push_back(i);
        end else begin
            for (int i = 0; i < 8; i++) if (list[i]) order.push_back(i);
            if (list[8]) order.push_back(15);
        end
        sp = sp0;
        faulted = 0;
        for (int k = 0; k < order.size(); k++) begin
            e = '0;
            e.busy = 1;
            e.stall = 1;
            if (push ? (sp <= top) : (sp >= bot)) begin
                e.fault = 1;
                exp_q.push_back(e);
                sp_q.push_back(sp);
                faulted = 1;
                break;
            end
            e.hc  = push ? 3'd1 : 3'd2;
            e.ri  = 4'(order[k]);
            e.mwe = push;
            exp_q.push_back(e);
            sp_q.push_back(sp);
            sp = push ? sp - 1 : sp + 1;
        end
        e = '0;
        e.busy = 1;
        e.stall = 1;
        if (!push && !faulted && order.size() > 0) begin
            exp_q.push_back(e);
            sp_q.push_back(sp);
        end
        e.done = 1;
        exp_q.push_back(e);
        sp_q.push_back(sp);
        for (int k = 0; k + 1 < exp_q.size(); k++) begin
            if (exp_q[k].hc == 3'd2) begin
                exp_q[k+1].rwe = 1;
                exp_q[k+1].wbi = exp_q[k].ri;
            end
        end
    endtask

    task automatic run(input string tag, input logic [8:0] list, input logic push,
                       input logic kernel, input int unsigned sp0);
        obs_t e;
        build(list, push, kernel, sp0);
        @(posedge clock); #1;
        bus.start = 1;
        bus.is_push = push;
        bus.register_list = list;
        bus.is_kernel = kernel;
        bus.current_SP = sp0;
        @(negedge clock);
        e = '0;
        e.stall = 1;
        check({tag, "/start"}, 32'(sample()), 32'(e));
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clock); #1;
            bus.start = 1'($urandom);
            bus.is_push = 1'($urandom);
            bus.register_list = 9'($urandom);
            bus.is_kernel = 1'($urandom);
            bus.current_SP = sp_q[k];
            @(negedge clock);
            check($sformatf("%s/c%0d", tag, k), 32'(sample()), 32'(exp_q[k]));
        end
        @(posedge clock); #1;
        bus.start = 0;
        @(negedge clock);
        check({tag, "/idle"}, 32'(sample()), 32'(0));
    endtask

    initial begin
        logic [8:0]  l;
        logic        p, kr;
        int unsigned sp;
        bus.start = 1;
        bus.is_push = 0;
        bus.register_list = 9'h1FF;
        bus.is_kernel = 0;
        bus.current_SP = 0;
        #1;
        check("reset", 32'(sample()), 32'(0));
        @(negedge clock);
        bus.start = 0;
        reset = 0;

        run("upush",   9'h103, 1, 0, 8191);
        run("upop",    9'h103, 0, 0, 8188);
        run("kovf",    9'h0FF, 1, 1, 4098);
        run("undf",    9'h001, 0, 0, 8191);
        run("empty",   9'h000, 1, 0, 8000);
        run("kpopall", 9'h1FF, 0, 1, 5000);

        // Reset in the middle of a pop with a write-back pending.
        @(posedge clock); #1;
        bus.start = 1;
        bus.is_push = 0;
        bus.register_list = 9'h103;
        bus.is_kernel = 0;
        bus.current_SP = 8188;
        @(posedge clock); #1;
        bus.start = 0;
        @(negedge clock);
        check("mid/first", 32'(bus.handler_control), 32'(HANDLER_POP));
        @(posedge clock); #1;
        bus.current_SP = 8189;
        bus.start = 1;
        reset = 1;
        #1;
        check("mid/rst", 32'(sample()), 32'(0));
        @(negedge clock);
        check("mid/hold", 32'(sample()), 32'(0));
        bus.start = 0;
        reset = 0;
        run("after", 9'h103, 0, 0, 8188);

        for (int t = 0; t < 40; t++) begin
            l  = 9'($urandom);
            p  = 1'($urandom);
            kr = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                sp = $urandom;
            else if (p)
                sp = (kr ? K_TOP : U_TOP) + $urandom_range(0, 12);
            else
                sp = (kr ? K_BOT : U_BOT) - $urandom_range(0, 12);
            run($sformatf("rnd%0d", t), l, p, kr, sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
